// File: rtl/txrx_sched_pkg.sv
// txrx_sched_pkg: shared types and defaults for the half-duplex TX/RX scheduler.
package txrx_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    TX_GUARD = 3'd1,
    TX_RUN   = 3'd2,
    TX_DRAIN = 3'd3,
    RX_GUARD = 3'd4,
    RX_RUN   = 3'd5
  } state_t;

  localparam int DEF_GUARD_CYCLES = 16;
  localparam int DEF_DRAIN_CYCLES = 32;
  localparam int DEF_RX_TIMEOUT   = 4096;

  // Largest of three interval lengths; sizes the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/txrx_sched_cnt.sv
// txrx_sched_cnt: saturating interval counter shared by every scheduler state.
// Clear has priority over enable; the count sticks at all-ones instead of wrapping.
module txrx_sched_cnt
  import txrx_sched_pkg::*;
#(
  parameter int CNT_W = 13
) (
  input  logic             inClock,
  input  logic             inReset,
  input  logic             inClear,
  input  logic             inEnable,
  input  logic [CNT_W-1:0] inTerminal,
  output logic [CNT_W-1:0] outCount,
  output logic             outAtTerminal
);

  // Count up with clear and saturation.
  always_ff @(posedge inClock) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!inReset) begin
      outCount <= '0;
    end else if (inClear) begin
      outCount <= '0;
    end else if (inEnable && (outCount != '1)) begin
      outCount <= outCount + CNT_W'(1);
    end
  end

  assign outAtTerminal = (outCount == inTerminal);

endmodule

// File: rtl/txrx_sched.sv
// txrx_sched: half-duplex TX/RX scheduler for the MSK transceiver datapath.
// Sequences guard/drain intervals, paces inFIFO pops against the coder and
// gates CDR bits into outFIFO with a sticky overflow flag.
// Optional: define TXRX_TX_PREEMPT_EN to let pending TX data preempt RX_RUN.
module txrx_sched
  import txrx_sched_pkg::*;
#(
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int RX_TIMEOUT   = DEF_RX_TIMEOUT,
  parameter int CNT_W        = $clog2(max3(GUARD_CYCLES, DRAIN_CYCLES, RX_TIMEOUT) + 1)
) (
  input  logic               inClock,
  input  logic               inReset,
  input  logic               inTxFifoEmpty,
  input  logic               inCoderReady,
  input  logic               inRxRequest,
  input  logic               inCdrFlag,
  input  logic               inRxFifoFull,
  input  logic               inClearOverflow,
  output logic               outTxReadEnable,
  output logic               outCoderEmpty,
  output logic               outRxEnable,
  output logic               outRxWriteEnable,
  output logic               outTxDone,
  output logic               outRxOverflow,
  output logic [STATE_W-1:0] outState
);

  localparam logic [STATE_W-1:0] S_IDLE     = IDLE;
  localparam logic [STATE_W-1:0] S_TX_GUARD = TX_GUARD;
  localparam logic [STATE_W-1:0] S_TX_RUN   = TX_RUN;
  localparam logic [STATE_W-1:0] S_TX_DRAIN = TX_DRAIN;
  localparam logic [STATE_W-1:0] S_RX_GUARD = RX_GUARD;
  localparam logic [STATE_W-1:0] S_RX_RUN   = RX_RUN;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(RX_TIMEOUT - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] nextState;
  logic [CNT_W-1:0]   cntTerminal;
  logic [CNT_W-1:0]   cntValue;
  logic               cntAtTerminal;
  logic               cntClear;
  logic               txRun;
  logic               rxRun;

  assign txRun = (state == S_TX_RUN);
  assign rxRun = (state == S_RX_RUN);

  // Pick the terminal count that applies to the current state.
  always_comb begin
    // NOTE: default first so no path through the block leaves a value held (no latch).
    cntTerminal = '1;
    case (state)
      S_TX_GUARD, S_RX_GUARD: cntTerminal = GUARD_LAST;
      S_TX_DRAIN:             cntTerminal = DRAIN_LAST;
      S_RX_RUN:               cntTerminal = RX_LAST;
      default:                cntTerminal = '1;
    endcase
  end

  // Counter restarts on every state entry and on each received CDR bit.
  assign cntClear = (nextState != state) || (rxRun && inCdrFlag);

  txrx_sched_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .inClock      (inClock),
    .inReset      (inReset),
    .inClear      (cntClear),
    .inEnable     (1'b1),
    .inTerminal   (cntTerminal),
    .outCount     (cntValue),
    .outAtTerminal(cntAtTerminal)
  );

  // Next-state decode; TX wins over RX when both are pending in IDLE.
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: begin
        if (!inTxFifoEmpty)   nextState = S_TX_GUARD;
        else if (inRxRequest) nextState = S_RX_GUARD;
      end
      S_TX_GUARD: if (cntAtTerminal) nextState = S_TX_RUN;
      S_TX_RUN:   if (inCoderReady && inTxFifoEmpty) nextState = S_TX_DRAIN;
      S_TX_DRAIN: if (cntAtTerminal) nextState = S_IDLE;
      S_RX_GUARD: if (cntAtTerminal) nextState = S_RX_RUN;
      S_RX_RUN: begin
`ifdef TXRX_TX_PREEMPT_EN
        if (!inTxFifoEmpty)                     nextState = S_TX_GUARD;
        else if (!inRxRequest || cntAtTerminal) nextState = S_IDLE;
`else
        if (!inRxRequest || cntAtTerminal) nextState = S_IDLE;
`endif
      end
      default: nextState = S_IDLE;
    endcase
  end

  // State register plus registered status outputs.
  always_ff @(posedge inClock) begin
    if (!inReset) begin
      state         <= S_IDLE;
      outTxDone     <= 1'b0;
      outRxEnable   <= 1'b0;
      outRxOverflow <= 1'b0;
    end else begin
      state       <= nextState;
      outTxDone   <= (state == S_TX_DRAIN) && (nextState == S_IDLE);
      outRxEnable <= (nextState == S_RX_RUN);
      // Set wins over clear so a loss in the clearing cycle is not hidden.
      if (rxRun && inCdrFlag && inRxFifoFull) outRxOverflow <= 1'b1;
      else if (inClearOverflow)               outRxOverflow <= 1'b0;
    end
  end

  assign outCoderEmpty    = txRun ? inTxFifoEmpty : 1'b1;
  assign outTxReadEnable  = txRun && inCoderReady && !inTxFifoEmpty;
  assign outRxWriteEnable = rxRun && inCdrFlag && !inRxFifoFull;
  assign outState         = state;

endmodule

// File: tb/tb_txrx_sched.sv
// tb_txrx_sched: directed test of txrx_sched (GUARD=16, DRAIN=32, RX_TIMEOUT=64).
module tb_txrx_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       txEmpty;
  logic       coderReady;
  logic       rxRequest;
  logic       cdrFlag;
  logic       rxFull;
  logic       clearOvf;
  logic       txRe;
  logic       coderEmpty;
  logic       rxEn;
  logic       rxWe;
  logic       txDone;
  logic       rxOvf;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  txrx_sched #(
    .GUARD_CYCLES(16),
    .DRAIN_CYCLES(32),
    .RX_TIMEOUT  (64)
  ) dut (
    .inClock         (clock),
    .inReset         (reset),
    .inTxFifoEmpty   (txEmpty),
    .inCoderReady    (coderReady),
    .inRxRequest     (rxRequest),
    .inCdrFlag       (cdrFlag),
    .inRxFifoFull    (rxFull),
    .inClearOverflow (clearOvf),
    .outTxReadEnable (txRe),
    .outCoderEmpty   (coderEmpty),
    .outRxEnable     (rxEn),
    .outRxWriteEnable(rxWe),
    .outTxDone       (txDone),
    .outRxOverflow   (rxOvf),
    .outState        (state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int pops;
    int bits;
    int writes;
    logic popped;

    reset = 1'b0; txEmpty = 1'b1; coderReady = 1'b0; rxRequest = 1'b0;
    cdrFlag = 1'b0; rxFull = 1'b0; clearOvf = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state), 0);
    check("rst_txRe", 32'(txRe), 0);
    check("rst_coderEmpty", 32'(coderEmpty), 1);
    check("rst_rxWe", 32'(rxWe), 0);
    check("rst_txDone", 32'(txDone), 0);
    check("rst_rxOvf", 32'(rxOvf), 0);
    check("rst_rxEn", 32'(rxEn), 0);

    // Guard / run / drain with 3 bits and ready every 8 cycles.
    reset = 1'b1;
    txEmpty = 1'b0;
    tick();
    n = 0;
    while (state == 3'd1 && n < 100) begin n++; tick(); end
    check("tx_guard_cycles", 32'(n), 16);
    check("tx_run_entry", 32'(state), 2);
    bits = 3; pops = 0; n = 0;
    while (state == 3'd2 && n < 200) begin
      coderReady = (n % 8 == 7);
      txEmpty = (bits == 0);
      #1;
      if (n == 0) check("coder_empty_run", 32'(coderEmpty), 0);
      popped = txRe;
      if (popped) pops++;
      tick();
      if (popped) bits--;
      n++;
    end
    coderReady = 1'b0;
    check("tx_pops", 32'(pops), 3);
    check("tx_run_cycles", 32'(n), 32);
    check("tx_drain_entry", 32'(state), 3);
    n = 0;
    while (state == 3'd3 && n < 100) begin n++; tick(); end
    check("tx_drain_cycles", 32'(n), 32);
    check("tx_done_state", 32'(state), 0);
    check("tx_done_pulse", 32'(txDone), 1);
    tick();
    check("tx_done_clear", 32'(txDone), 0);
    check("idle_after_tx", 32'(state), 0);

    // TX beats RX in IDLE.
    rxRequest = 1'b1;
    txEmpty = 1'b0;
    tick();
    check("priority", 32'(state), 1);
    reset = 1'b0;
    tick();
    check("prio_reset", 32'(state), 0);
    reset = 1'b1; rxRequest = 1'b0; txEmpty = 1'b1;
    tick();

    // RX bits with overflow on the 4th flag.
    rxRequest = 1'b1;
    tick();
    check("rx_guard", 32'(state), 4);
    check("rx_en_guard", 32'(rxEn), 0);
    repeat (16) tick();
    check("rx_run", 32'(state), 5);
    check("rx_en_run", 32'(rxEn), 1);
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      cdrFlag = 1'b1;
      rxFull = (i == 3);
      #1;
      if (rxWe) writes++;
      tick();
      cdrFlag = 1'b0;
      rxFull = 1'b0;
      tick();
    end
    check("rx_writes", 32'(writes), 4);
    check("ovf_set", 32'(rxOvf), 1);
    repeat (3) tick();
    check("ovf_sticky", 32'(rxOvf), 1);
    clearOvf = 1'b1;
    tick();
    clearOvf = 1'b0;
    check("ovf_clear", 32'(rxOvf), 0);
    cdrFlag = 1'b1; rxFull = 1'b1; clearOvf = 1'b1;
    #1;
    check("we_when_full", 32'(rxWe), 0);
    tick();
    cdrFlag = 1'b0; rxFull = 1'b0; clearOvf = 1'b0;
    check("ovf_set_wins", 32'(rxOvf), 1);
    clearOvf = 1'b1;
    tick();
    clearOvf = 1'b0;
    check("ovf_clear2", 32'(rxOvf), 0);

    // Request drop, then timeout.
    rxRequest = 1'b0;
    tick();
    check("rx_req_exit", 32'(state), 0);
    check("rx_en_exit", 32'(rxEn), 0);
    rxRequest = 1'b1;
    tick();
    repeat (16) tick();
    check("rx_run2", 32'(state), 5);
    n = 0;
    while (state == 3'd5 && n < 200) begin n++; tick(); end
    check("rx_timeout_cycles", 32'(n), 64);
    check("rx_timeout_idle", 32'(state), 0);
    rxRequest = 1'b0;
    tick();
    check("rx_en_after_timeout", 32'(rxEn), 0);
    check("idle_after_timeout", 32'(state), 0);

    // Reset in the middle of a TX burst.
    txEmpty = 1'b0;
    tick();
    repeat (16) tick();
    check("tx_run_again", 32'(state), 2);
    coderReady = 1'b1;
    #1;
    check("pop_before_reset", 32'(txRe), 1);
    reset = 1'b0;
    tick();
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_txRe", 32'(txRe), 0);
    check("mid_rst_coderEmpty", 32'(coderEmpty), 1);
    check("mid_rst_txDone", 32'(txDone), 0);
    reset = 1'b1; coderReady = 1'b0; txEmpty = 1'b1;
    tick();

    // TX data arriving during RX_RUN.
    rxRequest = 1'b1;
    tick();
    repeat (16) tick();
    check("rx_run3", 32'(state), 5);
    txEmpty = 1'b0;
    cdrFlag = 1'b1;
    #1;
    check("we_preempt_cycle", 32'(rxWe), 1);
    tick();
    cdrFlag = 1'b0;
`ifdef TXRX_TX_PREEMPT_EN
    check("preempt_state", 32'(state), 1);
    check("preempt_rx_en", 32'(rxEn), 0);
`else
    check("no_preempt_state", 32'(state), 5);
    repeat (3) tick();
    check("no_preempt_hold", 32'(state), 5);
    rxRequest = 1'b0;
    tick();
    check("no_preempt_exit", 32'(state), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
